ascon_permutation_engine: RTL and testbench

- Iterative Ascon permutation core, parametrised in rounds-per-cycle (UNROLL).
- Run-time mode selects p12, p8 or p6.
- Owns its own round counter and round-constant generation, and exposes a start/busy/done handshake; no external round index is needed.
- Sits between the Ascon-128 mode FSM (init, associated data, plaintext, finalisation) and the 320-bit state register path.

---
 rtl/ascon_pack.sv | 48 ++++
 rtl/ascon_round.sv | 47 ++++
 rtl/ascon_permutation_engine.sv | 98 +++++++++
 tb/tb_ascon_permutation_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared Ascon types, round-constant helper and linear-layer rotation amounts
// used by the iterative permutation engine and its round datapath.
package ascon_pack;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  typedef enum logic [1:0] {
    P12 = 2'b00,
    P8  = 2'b01,
    P6  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } perm_fsm_t;

  // Every variant ends after round 11, so the counter always finishes at 12.
  localparam logic [3:0] ROUND_END = 4'd12;

  localparam int unsigned ROT_A [5] = '{32'd19, 32'd61, 32'd1, 32'd10, 32'd7};
  localparam int unsigned ROT_B [5] = '{32'd28, 32'd39, 32'd6, 32'd17, 32'd41};

  function automatic logic [7:0] round_constant(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  // Reserved encoding 2'b11 falls through to the full p12 schedule.
  function automatic logic [3:0] first_round(input logic [1:0] mode);
    case (mode)
      P8:      return 4'd4;
      P6:      return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (32'd64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box and
// linear diffusion layer.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state,
  input  logic [3:0] round_idx,
  output type_state  result
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Full round datapath evaluated in place on local lane copies.
  always_comb begin
    x0 = state.x0;
    x1 = state.x1;
    x2 = state.x2 ^ {56'd0, round_constant(round_idx)};
    x3 = state.x3;
    x4 = state.x4;

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    result.x0 = x0 ^ ror64(x0, ROT_A[0]) ^ ror64(x0, ROT_B[0]);
    result.x1 = x1 ^ ror64(x1, ROT_A[1]) ^ ror64(x1, ROT_B[1]);
    result.x2 = x2 ^ ror64(x2, ROT_A[2]) ^ ror64(x2, ROT_B[2]);
    result.x3 = x3 ^ ror64(x3, ROT_A[3]) ^ ror64(x3, ROT_B[3]);
    result.x4 = x4 ^ ror64(x4, ROT_A[4]) ^ ror64(x4, ROT_B[4]);
  end

endmodule

// File: rtl/ascon_permutation_engine.sv
// Iterative Ascon p12/p8/p6 permutation with start/busy/done handshake,
// evaluating UNROLL rounds per clock from an internal round counter.
module ascon_permutation_engine
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
)
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  logic       abort_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o
);

  if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
    $error("ascon_permutation_engine: UNROLL must be 1 or 2");
  end

  localparam logic [3:0] STEP = 4'(UNROLL);

  perm_fsm_t  fsm_r;
  type_state  state_r;
  logic [3:0] rnd_r;
  logic       busy_r;
  logic       done_r;

  logic       accept_s;
  logic       advance_s;
  type_state  src_s;
  logic [3:0] base_s;
  logic [3:0] next_rnd_s;
  type_state  chain_s [UNROLL+1];

  // A new start bypasses the register so the first round group lands on the start edge.
  always_comb begin
    accept_s  = start_i && (fsm_r == IDLE || fsm_r == DONE);
    advance_s = accept_s || (fsm_r == RUN);
    if (accept_s) begin
      src_s  = state_i;
      base_s = first_round(mode_i);
    end else begin
      src_s  = state_r;
      base_s = rnd_r;
    end
    next_rnd_s = base_s + STEP;
  end

  assign chain_s[0] = src_s;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_round u_round (
      .state     (chain_s[k]),
      .round_idx (base_s + 4'(k)),
      .result    (chain_s[k+1])
    );
  end

  // Control FSM; abort wins over start and leaves the state register untouched.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_r   <= IDLE;
      state_r <= '0;
      rnd_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (abort_i) begin
      fsm_r  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (advance_s) begin
      state_r <= chain_s[UNROLL];
      rnd_r   <= next_rnd_s;
      if (next_rnd_s == ROUND_END) begin
        fsm_r  <= DONE;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        fsm_r  <= RUN;
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      fsm_r  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end
  end

  assign state_o = state_r;
  assign busy_o  = busy_r;
  assign done_o  = done_r;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Directed bench for the Ascon permutation engine, running UNROLL=1 and
// UNROLL=2 instances side by side against a table-driven reference model.
module tb_ascon_permutation_engine;
  import ascon_pack::*;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic       clock_i  = 1'b0;
  logic       resetb_i = 1'b1;
  logic       start_i  = 1'b0;
  logic       abort_i  = 1'b0;
  logic [1:0] mode_i   = 2'b00;
  type_state  state_i  = '0;

  type_state  st1, st2;
  logic       busy1, done1, busy2, done2;

  int vectors = 0;
  int fails   = 0;
  int lat1, lat2, lat1b, lat2b, dn1, dn2, bs1, bs2;
  type_state res1, res2, vec_s, exp12, exp8, exp6, exp_ab1, exp_ab2;

  always #5 clock_i = ~clock_i;

  ascon_permutation_engine #(.UNROLL(1)) dut_u1 (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .mode_i(mode_i),
    .abort_i(abort_i), .state_i(state_i), .state_o(st1), .busy_o(busy1), .done_o(done1));

  ascon_permutation_engine #(.UNROLL(2)) dut_u2 (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .mode_i(mode_i),
    .abort_i(abort_i), .state_i(state_i), .state_o(st2), .busy_o(busy2), .done_o(done2));

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference: per-column table S-box, rounds r0 .. r0+cnt-1.
  function automatic type_state model_perm(input type_state s, input int r0, input int cnt);
    logic [63:0] x [5];
    logic [4:0]  col, sb;
    type_state   o;
    x[0] = s.x0; x[1] = s.x1; x[2] = s.x2; x[3] = s.x3; x[4] = s.x4;
    for (int r = r0; r < r0 + cnt; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        sb  = SBOX[col];
        x[0][b] = sb[4]; x[1][b] = sb[3]; x[2][b] = sb[2]; x[3][b] = sb[1]; x[4][b] = sb[0];
      end
      x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    o.x0 = x[0]; o.x1 = x[1]; o.x2 = x[2]; o.x3 = x[3]; o.x4 = x[4];
    return o;
  endfunction

  task automatic launch(input logic [1:0] m);
    @(negedge clock_i);
    mode_i  = m;
    state_i = vec_s;
    start_i = 1'b1;
  endtask

  // Watches ncyc edges after a launch; edge k is the k-th edge counting the start edge as 1.
  task automatic observe(input int ncyc, input bit hold, input int pulse_at, input int abort_at);
    lat1 = -1; lat2 = -1; lat1b = -1; lat2b = -1;
    dn1 = 0; dn2 = 0; bs1 = 0; bs2 = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock_i);
      if (done1) begin
        dn1++;
        if (lat1 < 0) begin lat1 = k; res1 = st1; end
        else if (lat1b < 0) lat1b = k;
      end
      if (done2) begin
        dn2++;
        if (lat2 < 0) begin lat2 = k; res2 = st2; end
        else if (lat2b < 0) lat2b = k;
      end
      if (busy1) bs1++;
      if (busy2) bs2++;
      if (!hold) start_i = (k + 1 == pulse_at);
      abort_i = (k + 1 == abort_at);
    end
  endtask

  task automatic test_reset;
    #2 resetb_i = 1'b0;
    #1;
    vectors++; if (st1 !== '0 || st2 !== '0) begin fails++; $display("FAIL reset_state: got %h / %h want 0", st1, st2); end
    vectors++; if ({busy1, done1, busy2, done2} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {busy1, done1, busy2, done2}); end
    #24 resetb_i = 1'b1;
    @(negedge clock_i);
    @(negedge clock_i);
    vectors++; if ({busy1, done1, busy2, done2} !== 4'b0000 || st1 !== '0) begin fails++; $display("FAIL reset_idle: got %b want 0000", {busy1, done1, busy2, done2}); end
  endtask

  task automatic test_p12;
    launch(2'b00);
    observe(14, 1'b0, 0, 0);
    vectors++; if (lat1 !== 12) begin fails++; $display("FAIL p12_u1_latency: got %0d want 12", lat1); end
    vectors++; if (res1 !== exp12) begin fails++; $display("FAIL p12_u1_result: got %h want %h", res1, exp12); end
    vectors++; if (bs1 !== 11) begin fails++; $display("FAIL p12_u1_busy_cycles: got %0d want 11", bs1); end
    vectors++; if (dn1 !== 1) begin fails++; $display("FAIL p12_u1_done_pulses: got %0d want 1", dn1); end
    vectors++; if (st1 !== exp12) begin fails++; $display("FAIL p12_u1_held: got %h want %h", st1, exp12); end
    vectors++; if (lat2 !== 6) begin fails++; $display("FAIL p12_u2_latency: got %0d want 6", lat2); end
    vectors++; if (res2 !== exp12) begin fails++; $display("FAIL p12_u2_result: got %h want %h", res2, exp12); end
    vectors++; if (bs2 !== 5) begin fails++; $display("FAIL p12_u2_busy_cycles: got %0d want 5", bs2); end
  endtask

  task automatic test_p8_p6;
    vectors++; if (round_constant(4'd0) !== 8'hF0) begin fails++; $display("FAIL rc_0: got %h want f0", round_constant(4'd0)); end
    vectors++; if (round_constant(4'd4) !== 8'hB4) begin fails++; $display("FAIL rc_4: got %h want b4", round_constant(4'd4)); end
    vectors++; if (round_constant(4'd6) !== 8'h96) begin fails++; $display("FAIL rc_6: got %h want 96", round_constant(4'd6)); end
    vectors++; if (round_constant(4'd11) !== 8'h4B) begin fails++; $display("FAIL rc_11: got %h want 4b", round_constant(4'd11)); end
    launch(2'b01);
    observe(10, 1'b0, 0, 0);
    vectors++; if (lat1 !== 8 || lat2 !== 4) begin fails++; $display("FAIL p8_latency: got %0d/%0d want 8/4", lat1, lat2); end
    vectors++; if (res1 !== exp8) begin fails++; $display("FAIL p8_u1_result: got %h want %h", res1, exp8); end
    vectors++; if (res2 !== exp8) begin fails++; $display("FAIL p8_u2_result: got %h want %h", res2, exp8); end
    launch(2'b10);
    observe(8, 1'b0, 0, 0);
    vectors++; if (lat1 !== 6 || lat2 !== 3) begin fails++; $display("FAIL p6_latency: got %0d/%0d want 6/3", lat1, lat2); end
    vectors++; if (res1 !== exp6) begin fails++; $display("FAIL p6_u1_result: got %h want %h", res1, exp6); end
    vectors++; if (res2 !== exp6) begin fails++; $display("FAIL p6_u2_result: got %h want %h", res2, exp6); end
    launch(2'b11);
    observe(14, 1'b0, 0, 0);
    vectors++; if (lat1 !== 12 || lat2 !== 6) begin fails++; $display("FAIL reserved_latency: got %0d/%0d want 12/6", lat1, lat2); end
    vectors++; if (res2 !== exp12) begin fails++; $display("FAIL reserved_result: got %h want %h", res2, exp12); end
  endtask

  task automatic test_back_to_back;
    launch(2'b10);
    observe(12, 1'b1, 0, 0);
    vectors++; if (lat1 !== 6 || lat1b !== 12) begin fails++; $display("FAIL b2b_u1_done_edges: got %0d,%0d want 6,12", lat1, lat1b); end
    vectors++; if (lat2 !== 3 || lat2b !== 6) begin fails++; $display("FAIL b2b_u2_done_edges: got %0d,%0d want 3,6", lat2, lat2b); end
    vectors++; if (dn2 !== 4) begin fails++; $display("FAIL b2b_u2_done_pulses: got %0d want 4", dn2); end
    vectors++; if (bs1 !== 10 || bs2 !== 8) begin fails++; $display("FAIL b2b_busy_cycles: got %0d/%0d want 10/8", bs1, bs2); end
    vectors++; if (st1 !== exp6 || st2 !== exp6) begin fails++; $display("FAIL b2b_result: got %h / %h want %h", st1, st2, exp6); end
    start_i = 1'b0;
    abort_i = 1'b1;
    @(negedge clock_i);
    abort_i = 1'b0;
  endtask

  task automatic test_start_mid_run;
    launch(2'b00);
    observe(14, 1'b0, 5, 0);
    vectors++; if (lat1 !== 12 || lat2 !== 6) begin fails++; $display("FAIL midstart_latency: got %0d/%0d want 12/6", lat1, lat2); end
    vectors++; if (dn1 !== 1 || dn2 !== 1) begin fails++; $display("FAIL midstart_done_pulses: got %0d/%0d want 1/1", dn1, dn2); end
    vectors++; if (res1 !== exp12) begin fails++; $display("FAIL midstart_result: got %h want %h", res1, exp12); end
  endtask

  task automatic test_abort_reset;
    launch(2'b00);
    observe(16, 1'b0, 0, 6);
    vectors++; if (dn1 !== 0 || dn2 !== 0) begin fails++; $display("FAIL abort_no_done: got %0d/%0d want 0/0", dn1, dn2); end
    vectors++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin fails++; $display("FAIL abort_idle: got %b%b want 00", busy1, busy2); end
    vectors++; if (st1 !== exp_ab1) begin fails++; $display("FAIL abort_u1_held: got %h want %h", st1, exp_ab1); end
    vectors++; if (st2 !== exp_ab2) begin fails++; $display("FAIL abort_u2_held: got %h want %h", st2, exp_ab2); end
    launch(2'b00);
    observe(14, 1'b0, 0, 0);
    vectors++; if (lat1 !== 12 || res1 !== exp12) begin fails++; $display("FAIL abort_rerun: got %0d %h want 12 %h", lat1, res1, exp12); end

    launch(2'b00);
    observe(5, 1'b0, 0, 0);
    #2 resetb_i = 1'b0;
    #1;
    vectors++; if (st1 !== '0 || st2 !== '0) begin fails++; $display("FAIL midreset_state: got %h / %h want 0", st1, st2); end
    vectors++; if ({busy1, done1, busy2, done2} !== 4'b0000) begin fails++; $display("FAIL midreset_flags: got %b want 0000", {busy1, done1, busy2, done2}); end
    #1 resetb_i = 1'b1;
    observe(14, 1'b0, 0, 0);
    vectors++; if (dn1 !== 0 || dn2 !== 0) begin fails++; $display("FAIL midreset_no_done: got %0d/%0d want 0/0", dn1, dn2); end
    launch(2'b00);
    observe(14, 1'b0, 0, 0);
    vectors++; if (lat1 !== 12 || res1 !== exp12) begin fails++; $display("FAIL midreset_rerun_u1: got %0d %h want 12 %h", lat1, res1, exp12); end
    vectors++; if (lat2 !== 6 || res2 !== exp12) begin fails++; $display("FAIL midreset_rerun_u2: got %0d %h want 6 %h", lat2, res2, exp12); end
  endtask

  initial begin
    vec_s   = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
               64'h0011223344556677, 64'h8899aabbccddeeff};
    exp12   = model_perm(vec_s, 0, 12);
    exp8    = model_perm(vec_s, 4, 8);
    exp6    = model_perm(vec_s, 6, 6);
    exp_ab1 = model_perm(vec_s, 0, 5);
    exp_ab2 = model_perm(vec_s, 0, 10);
    test_reset;
    test_p12;
    test_p8_p6;
    test_back_to_back;
    test_start_mid_run;
    test_abort_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
